ethernet_tx_frame_buffer: RTL
=============================

Name: ethernet_tx_frame_buffer

Overview:
- Store-and-forward egress buffer between the ethernet controller's reply transmitter and the 10G MAC TX AXI-Stream port.
- The reply transmitter has no tready, so this block absorbs its beats unconditionally and replays whole frames to the MAC under tready backpressure.
- Pads runt frames, such as 42-byte ARP replies, to the Ethernet minimum with zero bytes.
- Drops frames that overflow the buffer or exceed the maximum length.

Parameters:
- DEPTH_LOG2, 9, log2 of buffer depth in 64-bit words (512 words). Usable capacity is 2^DEPTH_LOG2-1 words.
- MIN_FRAME_BYTES, 60, minimum emitted frame length in bytes, excluding FCS. Legal range 9..255.
- MAX_FRAME_WORDS, 190, maximum accepted frame length in beats (1518 bytes). Longer frames are dropped.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_tx_axis_tvalid  in  1  input beat valid; no backpressure exists on this side.
- i_tx_axis_tdata  in  64  input data; byte0 = tdata[7:0] is first on the wire.
- i_tx_axis_tlast  in  1  last beat of frame.
- i_tx_axis_tkeep  in  8  byte enables, contiguous from bit 0.
- o_tx_axis_tvalid  out  1  output beat valid (registered).
- o_tx_axis_tdata  out  64  output data (registered).
- o_tx_axis_tlast  out  1  output last (registered).
- o_tx_axis_tkeep  out  8  output byte enables (registered).
- i_tx_axis_tready  in  1  MAC ready.
- o_frame_pending  out  1  at least one committed frame not yet fully sent.
- o_overflow  out  1  one-cycle pulse when a frame is dropped for any reason.
- o_drop_count  out  16  dropped-frame counter; saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; wr_ptr = wr_commit = rd_ptr = 0.
  - Pending-frame count 0, write state IDLE, read state IDLE, drop flag clear.
  - A partially written or partially sent frame is discarded.
- Storage:
  - RAM of 2^DEPTH_LOG2 x 73 bits {last, keep, data}.
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - Full when wr_ptr+1 == rd_ptr.
- Write side, states IDLE / WRITE / DROP:
  - Beats with tvalid=0 are ignored; gaps mid-frame are legal.
  - IDLE/WRITE: each valid beat is written at wr_ptr, wr_ptr++, beat counter++.
  - If a valid beat arrives while full, or the beat counter would exceed MAX_FRAME_WORDS: that beat is not written, wr_ptr rewinds to wr_commit, and state goes to DROP.
  - DROP: discard beats until tlast, then return to IDLE. If the violating beat itself carried tlast, go straight to IDLE.
  - o_overflow pulses and o_drop_count increments on the cycle the violation is detected, once per frame.
  - Good tlast beat written: wr_commit <= wr_ptr+1, pending count ++, state IDLE.
- Read side, states IDLE / SEND / PAD:
  - IDLE -> SEND when pending count > 0 and the output register is empty or being consumed. RAM read latency is 1 cycle.
  - Output stage holds tdata/tkeep/tlast stable while tvalid & !tready. Once a frame starts it streams with no bubbles while tready=1.
  - The byte counter accumulates popcount(keep) per emitted beat.
  - If the stored last beat brings the total below MIN_FRAME_BYTES:
    - emit it with tlast=0, keep=0xFF, and unkept bytes forced to 0;
    - enter PAD and emit all-zero beats;
    - the final beat has tlast=1 and keep = low (MIN_FRAME_BYTES mod 8) bits set, or 0xFF if that value is 0;
    - total emitted = MIN_FRAME_BYTES exactly.
  - If the stored last beat brings the total to MIN_FRAME_BYTES or more, it is passed through unchanged.
  - When the tlast beat is accepted (tvalid & tready): rd_ptr is past the frame, pending count --, state IDLE.
- Simultaneous commit and send-complete in one cycle: pending count is unchanged.
- Latency: the first output beat is valid no earlier than 2 cycles after the input tlast beat. Frames are emitted in arrival order.
- o_frame_pending = (pending count != 0) | (read state != IDLE).

Test Plan:
- 8-beat 64-byte frame, last keep 0xFF, tready=1 -> identical 8 beats out, contiguous, first beat 2 cycles after input tlast, keep unchanged.
- 42-byte ARP frame (6 beats, last keep 0x03) -> 8 output beats:
  - beat5 keep 0xFF with bytes 2..7 = 0;
  - beat6 zero with keep 0xFF;
  - beat7 zero with keep 0x0F and tlast;
  - total 60 bytes.
- 8-beat frame with tready toggling 1,0,0,1 repeatedly -> output tdata/tkeep/tlast stable while stalled; no beat lost or duplicated.
- DEPTH_LOG2=4, tready=0, two back-to-back 8-beat frames -> second frame dropped, o_overflow one pulse, o_drop_count=1. With tready=1 afterwards, only the first frame emerges; the next 8-beat frame passes normally.
- 191-beat frame -> dropped at beat 191, o_drop_count increments, nothing emitted; a following 64-byte frame is emitted intact.
- Assert i_reset mid-input-frame and mid-output-frame -> all outputs 0 immediately, o_frame_pending=0. A subsequent 64-byte frame is emitted intact.

Source files
------------

// File: rtl/ethernet_tx_frame_buffer.sv
// Store-and-forward egress buffer between the reply transmitter (no tready)
// and the 10G MAC TX AXI-Stream port. Whole frames are committed before they
// are replayed; runts are zero-padded to MIN_FRAME_BYTES and frames that
// overflow the RAM or run past MAX_FRAME_WORDS are dropped.
module ethernet_tx_frame_buffer #(
  parameter int DEPTH_LOG2      = 9,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int MAX_FRAME_WORDS = 190
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_tx_axis_tvalid,
  input  logic [63:0] i_tx_axis_tdata,
  input  logic        i_tx_axis_tlast,
  input  logic [7:0]  i_tx_axis_tkeep,
  output logic        o_tx_axis_tvalid,
  output logic [63:0] o_tx_axis_tdata,
  output logic        o_tx_axis_tlast,
  output logic [7:0]  o_tx_axis_tkeep,
  input  logic        i_tx_axis_tready,
  output logic        o_frame_pending,
  output logic        o_overflow,
  output logic [15:0] o_drop_count
);

  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [11:0] MIN_B = 12'(MIN_FRAME_BYTES);
  localparam logic [15:0] MAX_W = 16'(MAX_FRAME_WORDS);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;
  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_SEND, R_PAD}   rstate_t;

  function automatic logic [3:0] popcnt(input logic [7:0] k);
    popcnt = '0;
    for (int i = 0; i < 8; i++) popcnt = popcnt + {3'b000, k[i]};
  endfunction

  function automatic logic [7:0] low_mask(input logic [11:0] n);
    low_mask = '0;
    for (int i = 0; i < 8; i++) low_mask[i] = (12'(i) < n);
  endfunction

  function automatic logic [63:0] zero_unkept(input logic [63:0] d, input logic [7:0] k);
    zero_unkept = '0;
    for (int i = 0; i < 8; i++) zero_unkept[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
  endfunction

  beat_t   mem [DEPTH];

  // write side
  ptr_t    wr_ptr, wr_commit;
  logic [15:0] beat_cnt;
  wstate_t wstate;
  // read side: rd_ptr frees space only at frame completion, rd_addr runs ahead
  ptr_t    rd_ptr, rd_addr;
  rstate_t rstate;
  beat_t   s1_q;
  logic    s1_vld, fetching;
  logic [11:0] byte_cnt;
  logic [DEPTH_LOG2:0] pend_cnt;

  ptr_t  wr_ptr_nxt;
  logic  full, wr_take, wr_viol, wr_ok, commit_ev, done_ev;
  logic  out_free, start, s1_adv, fetch_en, rem_last;
  logic [3:0]  s1_bytes;
  logic [11:0] new_total, rem;

  assign wr_ptr_nxt = wr_ptr + 1'b1;
  assign full       = (wr_ptr_nxt == rd_ptr);
  assign wr_take    = i_tx_axis_tvalid && (wstate != W_DROP);
  assign wr_viol    = wr_take && (full || (beat_cnt >= MAX_W));
  assign wr_ok      = wr_take && !wr_viol;
  assign commit_ev  = wr_ok && i_tx_axis_tlast;
  assign done_ev    = o_tx_axis_tvalid && i_tx_axis_tready && o_tx_axis_tlast;

  assign out_free   = !o_tx_axis_tvalid || i_tx_axis_tready;
  assign start      = (rstate == R_IDLE) && (pend_cnt != '0) && out_free;
  assign s1_adv     = (rstate == R_SEND) && s1_vld && out_free;
  // keep the fetch stage full until the stored last beat has been read
  assign fetch_en   = start ||
                      ((rstate == R_SEND) && fetching && (!s1_vld || (s1_adv && !s1_q.last)));

  assign s1_bytes   = popcnt(s1_q.keep);
  assign new_total  = byte_cnt + {8'h00, s1_bytes};
  assign rem        = MIN_B - byte_cnt;
  assign rem_last   = (rem <= 12'd8);

  assign o_frame_pending = (pend_cnt != '0) || (rstate != R_IDLE);

  // frame RAM write port
  always_ff @(posedge i_clk)
    if (wr_ok) mem[wr_ptr] <= {i_tx_axis_tlast, i_tx_axis_tkeep, i_tx_axis_tdata};

  // frame RAM read port, one cycle latency
  always_ff @(posedge i_clk)
    if (fetch_en) s1_q <= mem[rd_addr];

  // write FSM: accept beats, commit on good tlast, rewind and drop on violation
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr       <= '0;
      wr_commit    <= '0;
      beat_cnt     <= '0;
      wstate       <= W_IDLE;
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else begin
      o_overflow <= wr_viol;
      if (wr_viol) begin
        wr_ptr   <= wr_commit;
        beat_cnt <= '0;
        wstate   <= i_tx_axis_tlast ? W_IDLE : W_DROP;
        if (o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 1'b1;
      end else if (wr_ok) begin
        wr_ptr <= wr_ptr_nxt;
        if (i_tx_axis_tlast) begin
          wr_commit <= wr_ptr_nxt;
          beat_cnt  <= '0;
          wstate    <= W_IDLE;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          wstate   <= W_WRITE;
        end
      end else if ((wstate == W_DROP) && i_tx_axis_tvalid && i_tx_axis_tlast) begin
        wstate <= W_IDLE;
      end
    end
  end

  // committed-frame count; commit and completion in one cycle cancel out
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) pend_cnt <= '0;
    else case ({commit_ev, done_ev})
      2'b10:   pend_cnt <= pend_cnt + 1'b1;
      2'b01:   pend_cnt <= pend_cnt - 1'b1;
      default: pend_cnt <= pend_cnt;
    endcase
  end

  // read FSM: fetch pipeline, registered output stage and runt padding
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr           <= '0;
      rd_addr          <= '0;
      s1_vld           <= 1'b0;
      fetching         <= 1'b0;
      byte_cnt         <= '0;
      rstate           <= R_IDLE;
      o_tx_axis_tvalid <= 1'b0;
      o_tx_axis_tdata  <= '0;
      o_tx_axis_tlast  <= 1'b0;
      o_tx_axis_tkeep  <= '0;
    end else begin
      if (fetch_en) begin
        rd_addr <= rd_addr + 1'b1;
        s1_vld  <= 1'b1;
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end

      if (start)                    fetching <= 1'b1;
      else if (s1_adv && s1_q.last) fetching <= 1'b0;

      if (done_ev) begin
        o_tx_axis_tvalid <= 1'b0;
        rd_ptr           <= rd_addr;
        rstate           <= R_IDLE;
      end else begin
        case (rstate)
          R_IDLE: if (start) begin
            rstate   <= R_SEND;
            byte_cnt <= '0;
          end
          R_SEND: if (s1_adv) begin
            o_tx_axis_tvalid <= 1'b1;
            if (!s1_q.last) begin
              {o_tx_axis_tlast, o_tx_axis_tkeep, o_tx_axis_tdata} <= s1_q;
              byte_cnt <= new_total;
            end else if (new_total >= MIN_B) begin
              {o_tx_axis_tlast, o_tx_axis_tkeep, o_tx_axis_tdata} <= s1_q;
              byte_cnt <= '0;
            end else if (rem_last) begin
              // runt whose padding fits inside this beat
              o_tx_axis_tdata <= zero_unkept(s1_q.data, s1_q.keep);
              o_tx_axis_tkeep <= low_mask(rem);
              o_tx_axis_tlast <= 1'b1;
              byte_cnt        <= '0;
            end else begin
              o_tx_axis_tdata <= zero_unkept(s1_q.data, s1_q.keep);
              o_tx_axis_tkeep <= 8'hFF;
              o_tx_axis_tlast <= 1'b0;
              byte_cnt        <= byte_cnt + 12'd8;
              rstate          <= R_PAD;
            end
          end else if (out_free) begin
            o_tx_axis_tvalid <= 1'b0;
          end
          R_PAD: if (out_free) begin
            o_tx_axis_tvalid <= 1'b1;
            o_tx_axis_tdata  <= '0;
            if (rem_last) begin
              o_tx_axis_tkeep <= low_mask(rem);
              o_tx_axis_tlast <= 1'b1;
              byte_cnt        <= '0;
              rstate          <= R_SEND;
            end else begin
              o_tx_axis_tkeep <= 8'hFF;
              o_tx_axis_tlast <= 1'b0;
              byte_cnt        <= byte_cnt + 12'd8;
            end
          end
          default: rstate <= R_IDLE;
        endcase
      end
    end
  end

endmodule
